mux_scan_sequencer: RTL and testbench

Select-line sequencer and sampler that sits directly upstream/downstream of the CMOS 4:1 mux (`cmos_fourbyonemuxtrans`). It drives the mux selects `s0`/`s1` through all four channels. It holds each channel for a programmable settle time and samples the mux output `z` at the end of each dwell. It then delivers the four sampled bits as one frame over a valid/ready handshake. The block supports single-shot and continuous scanning.

---
 rtl/mux_scan_sequencer.sv | 83 ++++++++
 tb/tb_mux_scan_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps 4:1 mux selects, samples z per channel, emits 4-bit frames over valid/ready
module mux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               z,
    output logic               s0,
    output logic               s1,
    output logic [3:0]         frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               busy,
    output logic               overrun
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t             r_state, w_next;
    logic [DWELL_W-1:0] r_dwell, r_cnt;
    logic [1:0]         r_ch;
    logic [2:0]         r_acc;
    logic [3:0]         r_frame;
    logic               r_fv, r_ovr;
    logic               w_accept, w_sample, w_load;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_sample    = (r_state == SCAN) && (r_cnt == r_dwell);
    assign w_load      = w_sample && (r_ch == 2'd3);
    assign s0          = r_ch[0];
    assign s1          = r_ch[1];
    assign busy        = (r_state == SCAN);
    assign frame       = r_frame;
    assign frame_valid = r_fv;
    assign overrun     = r_ovr;

    // next state: enter SCAN on accepted start, leave after the last channel unless continuous
    always_comb begin
        w_next = w_accept ? SCAN : (w_load && !continuous) ? IDLE : r_state;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // dwell counter, channel index and partial-sample accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell <= '0;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_dwell <= dwell;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_acc   <= '0;
        end else if (w_sample) begin
            r_cnt <= '0;
            r_ch  <= r_ch + 2'd1;
            if (r_ch == 2'd3) r_acc <= '0;
            else              r_acc[r_ch] <= z;
        end else if (r_state == SCAN) begin
            r_cnt <= r_cnt + DWELL_W'(1);
        end
    end

    // frame output, valid/ready handshake and sticky overrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame <= '0;
            r_fv    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_frame <= w_load ? {z, r_acc} : r_frame;
            r_fv    <= w_load ? 1'b1 : (r_fv && frame_ready) ? 1'b0 : r_fv;
            r_ovr   <= w_accept ? 1'b0 : (w_load && r_fv && !frame_ready) ? 1'b1 : r_ovr;
        end
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed scans against a behavioural 4:1 mux with a frame scoreboard
module tb_mux_scan_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic [3:0] dwell = '0;
    logic       z;
    logic       s0, s1;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready = 1'b0;
    logic       busy, overrun;

    logic [3:0] ch_val = 4'b0000;
    logic       glitch = 1'b0;
    logic [1:0] sel;
    logic [3:0] exp_q[$];
    logic [3:0] exp_f;
    int         total = 0;
    int         bad = 0;

    mux_scan_sequencer #(.DWELL_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .dwell(dwell),
        .z(z), .s0(s0), .s1(s1), .frame(frame), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    assign sel = {s1, s0};
    assign z   = ch_val[sel] ^ glitch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: every handshake on the frame port is checked against the queue
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got frame %b with no expected frame", frame);
            end else begin
                exp_f = exp_q.pop_front();
                if (frame !== exp_f) begin
                    bad++;
                    $display("FAIL sb_frame: got %b expected %b at %0t", frame, exp_f, $time);
                end
            end
        end
    end

    initial begin
        // reset state
        tick();
        check("rst_sel", sel, 0);
        check("rst_frame", frame, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        tick();

        // single shot, dwell 0, a=1 b=0 c=1 d=1, frame left unconsumed
        ch_val = 4'b1101;
        dwell = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("d0_busy", busy, 1);
        check("d0_sel0", sel, 0);
        tick();
        check("d0_sel1", sel, 1);
        tick();
        check("d0_sel2", sel, 2);
        tick();
        check("d0_sel3", sel, 3);
        check("d0_fv_early", frame_valid, 0);
        tick();
        check("d0_fv", frame_valid, 1);
        check("d0_frame", frame, 4'b1101);
        check("d0_busy_end", busy, 0);
        check("d0_sel_end", sel, 0);

        // asynchronous reset mid-scan
        dwell = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("ar_busy_pre", busy, 1);
        check("ar_sel_pre", sel, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_sel", sel, 0);
        check("ar_frame", frame, 0);
        check("ar_fv", frame_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_ovr", overrun, 0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_busy_post", busy, 0);

        // dwell 3 with z glitching for the first 3 cycles of each channel
        ch_val = 4'b0110;
        frame_ready = 1'b1;
        exp_q.push_back(4'b0110);
        dwell = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                check("d3_sel", sel, k);
                if (k == 3 && c == 3) check("d3_fv_early", frame_valid, 0);
                glitch = (c != 3);
                tick();
            end
        end
        glitch = 1'b0;
        check("d3_fv", frame_valid, 1);
        check("d3_frame", frame, 4'b0110);
        check("d3_busy", busy, 0);
        tick();

        // continuous, dwell 1, consumer stalled, then released on a load edge
        ch_val = 4'b1010;
        frame_ready = 1'b0;
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b0101);
        dwell = 4'd1;
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("c_fv_early", frame_valid, 0);
        tick();
        check("c_fv1", frame_valid, 1);
        check("c_frame1", frame, 4'b1010);
        check("c_ovr1", overrun, 0);
        check("c_busy1", busy, 1);
        repeat (8) tick();
        check("c_fv2", frame_valid, 1);
        check("c_ovr2", overrun, 1);
        repeat (7) tick();
        frame_ready = 1'b1;
        tick();
        check("c_fv3", frame_valid, 1);
        check("c_frame3", frame, 4'b1010);
        ch_val = 4'b0101;
        tick();
        check("c_fv3_taken", frame_valid, 0);
        tick();
        continuous = 1'b0;
        repeat (5) tick();
        check("c_busy_last", busy, 1);
        check("c_fv_last_early", frame_valid, 0);
        tick();
        check("c_fv4", frame_valid, 1);
        check("c_frame4", frame, 4'b0101);
        check("c_busy4", busy, 0);
        check("c_sel4", sel, 0);
        tick();
        check("c_idle", busy, 0);

        // start and dwell changes mid-scan are ignored
        ch_val = 4'b1001;
        exp_q.push_back(4'b1001);
        dwell = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("m_ovr_clr", overrun, 0);
        check("m_busy", busy, 1);
        tick();
        tick();
        check("m_sel_e2", sel, 0);
        start = 1'b1;
        dwell = 4'd0;
        tick();
        start = 1'b0;
        check("m_sel_e3", sel, 1);
        tick();
        tick();
        check("m_sel_e5", sel, 1);
        tick();
        check("m_sel_e6", sel, 2);
        repeat (5) tick();
        check("m_sel_e11", sel, 3);
        check("m_fv_early", frame_valid, 0);
        tick();
        check("m_fv", frame_valid, 1);
        check("m_frame", frame, 4'b1001);
        check("m_busy_end", busy, 0);
        repeat (2) tick();

        check("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
